// File: rtl/vga_score_pkg.sv
// Shared types and constants for the score renderer: segment masks, glyph ROM, colours.
package vga_score_pkg;

  // Segment mask, bit 0 = a .. bit 6 = g.
  typedef logic [6:0] seg_mask_t;

  // 12-bit RGB pixel, {red, green, blue}.
  typedef logic [11:0] rgb_t;

  localparam rgb_t C_BLACK = 12'h000;
  localparam rgb_t C_WHITE = 12'hfff;
  localparam rgb_t C_FLASH = 12'hff0;

  // Seven-segment glyphs for 0-9; codes 10-15 are drawn blank.
  localparam seg_mask_t GLYPHS [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  // Top-band palette indexed by player-0 LSD; entries 7-15 fall back to black.
  localparam rgb_t BAND_PALETTE [8] = '{
    12'hfff, 12'h00f, 12'h0f0, 12'hf00, 12'h0ff, 12'hf0f, 12'hff0, 12'h000
  };

  function automatic rgb_t band_colour(input logic [3:0] nib);
    return (nib < 4'd7) ? BAND_PALETTE[nib[2:0]] : C_BLACK;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder with a blank override.
module seg7_decode
  import vga_score_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output seg_mask_t  seg_o
);

  // Blanking forces every segment off regardless of the digit value.
  always_comb begin
    seg_o = blank_i ? 7'h00 : GLYPHS[digit_i];
  end

endmodule

// File: rtl/vga_score_renderer.sv
// Two-player multi-digit score renderer with a score-coloured top band.
// Scores are latched on the vsync falling edge; pixel pipeline is two cycles deep.
// Optional macro SCORE_FLASH_EN: digits flash ff0/fff for 48 frames after a score change.
module vga_score_renderer
  import vga_score_pkg::*;
#(
  parameter int unsigned N_DIGITS = 2,
  parameter int unsigned BAND_H   = 190,
  parameter int unsigned X0       = 140,
  parameter int unsigned X1       = 340,
  parameter int unsigned Y0       = 200,
  parameter int unsigned SEG_W    = 50,
  parameter int unsigned SEG_T    = 10,
  parameter int unsigned SEG_L    = 30,
  parameter int unsigned DIG_GAP  = 10,
  parameter int unsigned LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            h_cnt,
  input  logic [9:0]            v_cnt,
  input  logic                  valid,
  input  logic                  vsync,
  input  logic [4*N_DIGITS-1:0] score0,
  input  logic [4*N_DIGITS-1:0] score1,
  output logic [3:0]            vgaRed,
  output logic [3:0]            vgaGreen,
  output logic [3:0]            vgaBlue
);

  localparam int unsigned DIG_H = 3 * SEG_T + 2 * SEG_L;
  localparam int unsigned PITCH = SEG_W + DIG_GAP;

  // ---------------- frame latch ----------------
  logic                  vsync_q;
  logic [4*N_DIGITS-1:0] shadow0_q, shadow0_d, shadow1_q, shadow1_d;
  logic                  vs_fall;

  // Capture new scores only on the vsync falling edge to avoid tearing.
  always_comb begin
    vs_fall   = vsync_q & ~vsync;
    shadow0_d = vs_fall ? score0 : shadow0_q;
    shadow1_d = vs_fall ? score1 : shadow1_q;
  end

  // Frame-latch state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q   <= 1'b1;
      shadow0_q <= '0;
      shadow1_q <= '0;
    end else begin
      vsync_q   <= vsync;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
    end
  end

`ifdef SCORE_FLASH_EN
  logic [5:0] flash0_q, flash0_d, flash1_q, flash1_d;
  logic [1:0] flash_on;

  // Reload on a latched change, otherwise count frames down to zero.
  always_comb begin
    flash0_d = flash0_q;
    flash1_d = flash1_q;
    if (vs_fall) begin
      if (score0 != shadow0_q)    flash0_d = 6'd48;
      else if (flash0_q != 6'd0)  flash0_d = flash0_q - 6'd1;
      if (score1 != shadow1_q)    flash1_d = 6'd48;
      else if (flash1_q != 6'd0)  flash1_d = flash1_q - 6'd1;
    end
    flash_on = {(flash1_q != 6'd0) && flash1_q[3], (flash0_q != 6'd0) && flash0_q[3]};
  end

  // Flash counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash0_q <= '0;
      flash1_q <= '0;
    end else begin
      flash0_q <= flash0_d;
      flash1_q <= flash1_d;
    end
  end
`endif

  // ---------------- stage 1: region classification ----------------
  logic       s1_valid_q, s1_valid_d, s1_band_q, s1_band_d, s1_hit_q, s1_hit_d;
  logic       s1_player_q, s1_player_d;
  logic [1:0] s1_dig_q, s1_dig_d;
  logic [9:0] s1_lx_q, s1_lx_d, s1_ly_q, s1_ly_d;

  // Find the digit cell under the beam; player 0 is searched first so it wins overlaps.
  always_comb begin
    int unsigned hx, vy, xs;
    hx          = 32'(h_cnt);
    vy          = 32'(v_cnt);
    xs          = 0;
    s1_valid_d  = valid;
    s1_band_d   = vy < BAND_H;
    s1_hit_d    = 1'b0;
    s1_player_d = 1'b0;
    s1_dig_d    = '0;
    s1_lx_d     = '0;
    s1_ly_d     = '0;
    if (vy >= Y0 && vy < Y0 + DIG_H) begin
      s1_ly_d = 10'(vy - Y0);
      for (int unsigned p = 0; p < 2; p++) begin
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
          xs = ((p == 0) ? X0 : X1) + k * PITCH;
          if (!s1_hit_d && hx >= xs && hx < xs + SEG_W) begin
            s1_hit_d    = 1'b1;
            s1_player_d = (p != 0);
            s1_dig_d    = 2'(k);
            s1_lx_d     = 10'(hx - xs);
          end
        end
      end
    end
  end

  // Stage-1 pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_band_q   <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_player_q <= 1'b0;
      s1_dig_q    <= '0;
      s1_lx_q     <= '0;
      s1_ly_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_band_q   <= s1_band_d;
      s1_hit_q    <= s1_hit_d;
      s1_player_q <= s1_player_d;
      s1_dig_q    <= s1_dig_d;
      s1_lx_q     <= s1_lx_d;
      s1_ly_q     <= s1_ly_d;
    end
  end

  // ---------------- stage 2: segment lookup and colour ----------------
  // Cell k (k = 0 leftmost) is blanked while it and all cells left of it are zero; LSD never.
  function automatic logic [N_DIGITS-1:0] lz_mask(input logic [4*N_DIGITS-1:0] s);
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int unsigned k = 0; k + 1 < N_DIGITS; k++) begin
      all_zero   = all_zero && (s[4*(N_DIGITS-1-k) +: 4] == 4'd0);
      lz_mask[k] = all_zero && (LZ_BLANK != 0);
    end
  endfunction

  logic [N_DIGITS-1:0] blank0, blank1;
  logic [3:0]          nib0, nib1;
  logic                bl0, bl1;
  seg_mask_t           mask0, mask1;

  // Pick the nibble and blank flag of the addressed cell for each player lane.
  always_comb begin
    blank0 = lz_mask(shadow0_q);
    blank1 = lz_mask(shadow1_q);
    nib0   = '0;
    nib1   = '0;
    bl0    = 1'b0;
    bl1    = 1'b0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (32'(s1_dig_q) == k) begin
        nib0 = shadow0_q[4*(N_DIGITS-1-k) +: 4];
        nib1 = shadow1_q[4*(N_DIGITS-1-k) +: 4];
        bl0  = blank0[k];
        bl1  = blank1[k];
      end
    end
  end

  seg7_decode u_dec0 (.digit_i(nib0), .blank_i(bl0), .seg_o(mask0));
  seg7_decode u_dec1 (.digit_i(nib1), .blank_i(bl1), .seg_o(mask1));

  seg_mask_t region;
  rgb_t      digit_colour, rgb_d, rgb_q;

  // Segment geometry; corners fall inside the horizontal bars only.
  always_comb begin
    int unsigned lx, ly;
    lx        = 32'(s1_lx_q);
    ly        = 32'(s1_ly_q);
    region[0] = ly < SEG_T;
    region[1] = lx >= SEG_W - SEG_T && ly >= SEG_T && ly < SEG_T + SEG_L;
    region[2] = lx >= SEG_W - SEG_T && ly >= 2 * SEG_T + SEG_L && ly < 2 * SEG_T + 2 * SEG_L;
    region[3] = ly >= 2 * SEG_T + 2 * SEG_L;
    region[4] = lx < SEG_T && ly >= 2 * SEG_T + SEG_L && ly < 2 * SEG_T + 2 * SEG_L;
    region[5] = lx < SEG_T && ly >= SEG_T && ly < SEG_T + SEG_L;
    region[6] = ly >= SEG_T + SEG_L && ly < 2 * SEG_T + SEG_L;
`ifdef SCORE_FLASH_EN
    digit_colour = flash_on[s1_player_q] ? C_FLASH : C_WHITE;
`else
    digit_colour = C_WHITE;
`endif
    rgb_d = C_BLACK;
    if (!s1_valid_q) begin
      rgb_d = C_BLACK;
    end else if (s1_band_q) begin
      rgb_d = band_colour(shadow0_q[3:0]);
    end else if (s1_hit_q && |((s1_player_q ? mask1 : mask0) & region)) begin
      rgb_d = digit_colour;
    end
  end

  // Registered RGB output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb_q <= C_BLACK;
    else     rgb_q <= rgb_d;
  end

  assign vgaRed   = rgb_q[11:8];
  assign vgaGreen = rgb_q[7:4];
  assign vgaBlue  = rgb_q[3:0];

endmodule

// File: doc/vga_score_renderer.md
Name: vga_score_renderer

Overview:
- Parametrised successor to the single-digit score pixel generator.
- Draws two players' multi-digit BCD scores as seven-segment glyphs, plus a score-coloured top band.
- Scores are latched once per frame to prevent tearing.
- Sits between the VGA timing controller (h_cnt/v_cnt/valid/vsync) and the 12-bit RGB pins, with a registered 2-cycle pixel pipeline.

Parameters:
- N_DIGITS, 2, BCD digits per player (1..4).
- BAND_H, 190, height in lines of the top colour band.
- X0, 140, left x of player-0 digit field.
- X1, 340, left x of player-1 digit field.
- Y0, 200, top y of digit fields.
- SEG_W, 50, digit width (horizontal segment length).
- SEG_T, 10, segment thickness.
- SEG_L, 30, vertical segment length; digit height = 3*SEG_T + 2*SEG_L.
- DIG_GAP, 10, horizontal gap between adjacent digits.
- LZ_BLANK, 1, 1 = blank leading zeros (the least-significant digit is always shown).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- h_cnt  in  10  horizontal pixel counter.
- v_cnt  in  10  vertical line counter.
- valid  in  1  active-video qualifier.
- vsync  in  1  vertical sync, active low.
- score0  in  4*N_DIGITS  player-0 BCD score; nibble 0 is the LSD.
- score1  in  4*N_DIGITS  player-1 BCD score.
- vgaRed  out  4  red channel, registered.
- vgaGreen  out  4  green channel, registered.
- vgaBlue  out  4  blue channel, registered.

Behaviour:
- Reset: asynchronous, active-high. All RGB = 0. Shadow scores = 0. Pipeline valid bits = 0. vsync history = 1.
- Frame latch:
  - vsync is registered each clk.
  - On a detected falling edge (previous = 1, current = 0), score0/score1 are copied into shadow registers.
  - All drawing uses the shadow registers only, so mid-frame input changes are invisible until the next falling edge.
- Pipeline, 2 cycles. Inputs at cycle n produce RGB at cycle n+2.
  - Stage 1 registers: valid, band hit, player hit, digit index, local x/y inside the digit cell.
  - Stage 2 registers: segment lookup and final colour.
- Pixel blanking: if valid was 0 at cycle n, RGB = 0 at cycle n+2.
- Regions are half-open, [start, end):
  - Band: v_cnt < BAND_H. Colour from shadow score0 nibble 0: 0 fff, 1 00f, 2 0f0, 3 f00, 4 0ff, 5 f0f, 6 ff0, any other value 000.
  - Digit cell k of player p (k = 0 is leftmost/most significant): x in [Xp + k*(SEG_W+DIG_GAP), +SEG_W), y in [Y0, Y0 + 3*SEG_T + 2*SEG_L).
- Segment geometry (lx, ly local to the cell):
  - a: ly < T.
  - g: T+L <= ly < 2T+L.
  - d: ly >= 2T+2L.
  - f: lx < T, T <= ly < T+L.
  - b: lx >= W-T, T <= ly < T+L.
  - e: lx < T, 2T+L <= ly < 2T+2L.
  - c: lx >= W-T, 2T+L <= ly < 2T+2L.
  - Corner pixels belong to the horizontal segment only.
- Glyphs: standard seven-segment encodings 0-9. Nibbles 10-15 are blank (no segment lit).
- Lit segment = fff; everything else = 000.
- Leading-zero blanking (LZ_BLANK = 1): a digit is blanked if it and every more-significant digit are 0, except the LSD. Example: with N_DIGITS = 3, score 007 shows "  7" and 000 shows "  0".
- Overlap: band takes priority over digit cells. Player-0 takes priority over player-1 if fields overlap.

Optional Feature:
- Macro: SCORE_FLASH_EN.
- Defined:
  - Per player, when a frame latch changes that player's shadow score, a 6-bit frame counter loads 48.
  - The counter decrements on each later vsync falling edge, saturating at 0.
  - While counter != 0 and counter bit 3 = 1, that player's digits are drawn in ff0 instead of fff.
  - A new change while flashing reloads 48.
  - Reset clears the counters.
- Undefined: no counters; digits are always fff.

Decomposition:
- Package vga_score_pkg holds:
  - 7-bit segment-mask typedef and the 16-entry glyph constant table.
  - Band palette constants.
  - 12-bit RGB typedef with constants C_BLACK, C_WHITE, C_FLASH.
- Sub-module seg7_decode (combinational): 4-bit BCD plus blank flag -> 7-bit segment mask (a..g). One instance per pipeline lane in stage 2.

Test Plan:
- Reset: assert rst mid-line with valid = 1 -> RGB = 000 immediately; after release, first pixel appears exactly 2 clks after the input.
- Band colour: shadow score0 = 0x03, v_cnt = 100, h_cnt = 5 -> RGB f00; nibble 0 = 9 -> 000.
- Glyph: score1 = 0x18, N_DIGITS = 2. Sweep player-1 field: digit 0 lights only b and c, e.g. (X1 + SEG_W - 1, Y0 + 15) = fff; digit 1 lights all 7 segments. (X1 + 5, Y0 + 5) = 000 (segment a off for "1").
- Tearing: change score0 from 0x05 to 0x06 while v_cnt = 250 -> remainder of frame still shows 5; after next vsync falling edge, 6 is shown.
- Leading-zero blanking: score0 = 0x00 with LZ_BLANK = 1 -> digit 0 cell is all 000, digit 1 shows 0. Score0 = 0xA4 -> left cell blank, right shows 4.
- SCORE_FLASH_EN defined: change score1 -> on the next 8 frames after the latch (counter 47..40) digits are ff0, then fff for 8 frames, alternating; after 48 frames, steady fff.
